// File: rtl/pc_npc_reg.sv
// pc_npc_reg: SPARC-style PC/nPC pair with delayed-branch, trap and error sequencing.
// Optional misaligned-redirect trap (type 0x07) is built when PC_ALIGN_CHECK_EN is defined.
module pc_npc_reg #(
   parameter int unsigned       WIDTH     = 32,
   parameter logic [WIDTH-1:0]  RESET_PC  = 32'h0000_0000,
   parameter logic [19:0]       TRAP_BASE = 20'h00000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             annul,
   input  logic [WIDTH-1:0] npc_plus4,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jmp_valid,
   input  logic [WIDTH-1:0] jmp_target,
   input  logic             trap_req,
   input  logic [7:0]       trap_type,
   input  logic             et,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] npc,
   output logic             pc_valid,
   output logic             trap_ack,
   output logic             error_mode,
   output logic             misalign
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      TRAP_LOAD = 2'd1,
      ERROR     = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] RESET_NPC = RESET_PC + 32'd4;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] npc_q, npc_d;
   logic             pv_q, pv_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] npc_sel;
   logic [7:0]       ttype;
   logic             trap_take;
   logic [WIDTH-1:0] vector;

   assign npc_sel = jmp_valid ? jmp_target :
                    br_taken  ? br_target  : npc_plus4;

`ifdef PC_ALIGN_CHECK_EN
   assign misalign  = (state_q == RUN) & ~stall
                    & (npc_sel[1:0] != 2'b00);
   assign trap_take = trap_req | misalign;
   assign ttype     = trap_req ? trap_type : 8'h07;
`else
   assign misalign  = 1'b0;
   assign trap_take = trap_req;
   assign ttype     = trap_type;
`endif

   assign vector = {TRAP_BASE, ttype, 4'b0000};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      npc_d   = npc_q;
      pv_d    = pv_q;
      ack_d   = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         RUN: begin
            // Trap entry wins over stall and every redirect
            if (trap_take) begin
               pv_d = 1'b0;
               if (et) begin
                  npc_d   = vector;
                  ack_d   = 1'b1;
                  state_d = TRAP_LOAD;
               end else begin
                  err_d   = 1'b1;
                  state_d = ERROR;
               end
            end else if (!stall) begin
               pc_d  = npc_q;
               npc_d = npc_sel;
               pv_d  = ~annul;
            end
         end
         TRAP_LOAD: begin
            if (!stall) begin
               pc_d    = npc_q;
               npc_d   = npc_plus4;
               pv_d    = 1'b1;
               state_d = RUN;
            end
         end
         ERROR: begin
            pv_d  = 1'b0;
            err_d = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         npc_q   <= RESET_NPC;
         pv_q    <= 1'b1;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         npc_q   <= npc_d;
         pv_q    <= pv_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign pc         = pc_q;
   assign npc        = npc_q;
   assign pc_valid   = pv_q;
   assign trap_ack   = ack_q;
   assign error_mode = err_q;

endmodule

// File: tb/tb_pc_npc_reg.sv
// Scoreboard bench for pc_npc_reg: expected pc/npc/flags queued per driven cycle.
// Covers sequencing, delay slot, annul, jump priority, stall, trap, wrap, error, reset.
module tb_pc_npc_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, annul, br_taken, jmp_valid, trap_req, et;
   logic [31:0] npc_plus4, br_target, jmp_target, pc, npc;
   logic [7:0]  trap_type;
   logic        pc_valid, trap_ack, error_mode, misalign;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] npc;
      logic        v;
      logic        ack;
      logic        err;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   // External PC4 adder
   assign npc_plus4 = npc + 32'd4;

   pc_npc_reg #(
      .WIDTH    (32),
      .RESET_PC (32'h0000_0000),
      .TRAP_BASE(20'h40000)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall),
      .annul     (annul),
      .npc_plus4 (npc_plus4),
      .br_taken  (br_taken),
      .br_target (br_target),
      .jmp_valid (jmp_valid),
      .jmp_target(jmp_target),
      .trap_req  (trap_req),
      .trap_type (trap_type),
      .et        (et),
      .pc        (pc),
      .npc       (npc),
      .pc_valid  (pc_valid),
      .trap_ack  (trap_ack),
      .error_mode(error_mode),
      .misalign  (misalign)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic s, input logic an,
                      input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt,
                      input logic t, input logic [7:0] tt,
                      input logic e);
      stall      = s;
      annul      = an;
      br_taken   = b;
      br_target  = bt;
      jmp_valid  = j;
      jmp_target = jt;
      trap_req   = t;
      trap_type  = tt;
      et         = e;
   endtask

   task automatic idle();
      drv(0, 0, 0, 32'h0, 0, 32'h0, 0, 8'h0, 1);
   endtask

   task automatic step(input string tag, input logic [31:0] epc,
                       input logic [31:0] enpc, input logic ev,
                       input logic eack, input logic eerr);
      exp_t e;
      e = '{pc: epc, npc: enpc, v: ev, ack: eack, err: eerr};
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".pc"},  pc,                 e.pc);
         chk({tag, ".npc"}, npc,                e.npc);
         chk({tag, ".v"},   {31'd0, pc_valid},  {31'd0, e.v});
         chk({tag, ".ack"}, {31'd0, trap_ack},  {31'd0, e.ack});
         chk({tag, ".err"}, {31'd0, error_mode},{31'd0, e.err});
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".pc"},  pc,                 32'h0);
      chk({tag, ".npc"}, npc,                32'h4);
      chk({tag, ".v"},   {31'd0, pc_valid},  32'd1);
      chk({tag, ".ack"}, {31'd0, trap_ack},  32'd0);
      chk({tag, ".err"}, {31'd0, error_mode},32'd0);
      chk({tag, ".mis"}, {31'd0, misalign},  32'd0);
   endtask

`ifdef PC_ALIGN_CHECK_EN
   localparam logic [31:0] E_PC  = 32'h4000_0070;
   localparam logic [31:0] E_NPC = 32'h4000_0074;
`else
   localparam logic [31:0] E_PC  = 32'h0000_0202;
   localparam logic [31:0] E_NPC = 32'h0000_0206;
`endif

   initial begin
      rst_n = 1'b0;
      idle();
      #12;
      chk_reset("rst");
      @(negedge clk);
      rst_n = 1'b1;

      step("seq1", 32'h4, 32'h8, 1, 0, 0);
      step("seq2", 32'h8, 32'hC, 1, 0, 0);

      drv(0, 0, 1, 32'h100, 0, 32'h0, 0, 8'h0, 1);
      step("br_ds", 32'hC, 32'h100, 1, 0, 0);
      idle();
      step("br_tg", 32'h100, 32'h104, 1, 0, 0);
      step("seq3", 32'h104, 32'h108, 1, 0, 0);

      drv(0, 1, 1, 32'h100, 0, 32'h0, 0, 8'h0, 1);
      step("an_ds", 32'h108, 32'h100, 0, 0, 0);
      idle();
      step("an_tg", 32'h100, 32'h104, 1, 0, 0);

      drv(0, 0, 1, 32'h500, 1, 32'h300, 0, 8'h0, 1);
      step("jmp_pri", 32'h104, 32'h300, 1, 0, 0);
      idle();
      step("jmp_tg", 32'h300, 32'h304, 1, 0, 0);

      drv(1, 1, 1, 32'h500, 1, 32'h600, 0, 8'h0, 1);
      step("stall", 32'h300, 32'h304, 1, 0, 0);

      drv(1, 0, 1, 32'h500, 0, 32'h0, 1, 8'h05, 1);
      step("trap", 32'h300, 32'h4000_0050, 0, 1, 0);
      drv(1, 1, 1, 32'h500, 1, 32'h600, 1, 8'h05, 1);
      step("tl_stall", 32'h300, 32'h4000_0050, 0, 0, 0);
      drv(0, 1, 1, 32'h500, 1, 32'h600, 1, 8'h05, 1);
      step("tl_load", 32'h4000_0050, 32'h4000_0054, 1, 0, 0);

      drv(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 8'h0, 1);
      step("wrap_j", 32'h4000_0054, 32'hFFFF_FFFC, 1, 0, 0);
      idle();
      step("wrap_a", 32'hFFFF_FFFC, 32'h0, 1, 0, 0);
      step("wrap_b", 32'h0, 32'h4, 1, 0, 0);

      drv(0, 0, 0, 32'h0, 1, 32'h202, 0, 8'h0, 1);
      #1;
`ifdef PC_ALIGN_CHECK_EN
      chk("mis_on", {31'd0, misalign}, 32'd1);
      step("mis_trap", 32'h0, 32'h4000_0070, 0, 1, 0);
      idle();
      step("mis_load", 32'h4000_0070, 32'h4000_0074, 1, 0, 0);
`else
      chk("mis_off", {31'd0, misalign}, 32'd0);
      step("mis_j", 32'h4, 32'h202, 1, 0, 0);
      idle();
      step("mis_tg", 32'h202, 32'h206, 1, 0, 0);
`endif

      drv(0, 0, 0, 32'h0, 0, 32'h0, 1, 8'h09, 0);
      step("err_in", E_PC, E_NPC, 0, 0, 1);
      for (int i = 0; i < 10; i++) begin
         drv(1'($urandom), 1'($urandom), 1'($urandom), $urandom,
             1'($urandom), $urandom, 1'($urandom), 8'($urandom),
             1'($urandom));
         step("err_hold", E_PC, E_NPC, 0, 0, 1);
      end
      idle();
      rst_n = 1'b0;
      #1;
      chk_reset("err_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step("post_err", 32'h4, 32'h8, 1, 0, 0);

      drv(0, 0, 0, 32'h0, 0, 32'h0, 1, 8'h05, 1);
      step("trap2", 32'h4, 32'h4000_0050, 0, 1, 0);
      rst_n = 1'b0;
      #1;
      chk_reset("mid_rst");
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      step("mid_run", 32'h4, 32'h8, 1, 0, 0);
      step("mid_run2", 32'h8, 32'hC, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_npc_reg.md
Name: pc_npc_reg

Overview:
- Architectural PC/nPC register pair for the SPARC-style fetch path.
- Holds the current fetch address `pc` and the delayed-branch successor `npc`.
- Drives `npc` into the downstream PC4 adder and consumes its `npc_plus4` result to sequence fetch.
- Selects among sequential, branch, jump and trap redirects, and implements stall, annul and trap entry with a small state machine.

Parameters:
- WIDTH, 32, address width (fixed 32 for the integer unit).
- RESET_PC, 32'h0000_0000, pc value after reset; npc resets to RESET_PC+4.
- TRAP_BASE, 20'h00000, upper 20 bits of the trap vector: vector = {TRAP_BASE, trap_type[7:0], 4'b0000}.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hold pc/npc/pc_valid this cycle.
- annul  in  1  annul the delay-slot instruction entering pc.
- npc_plus4  in  32  from PC4 adder; must equal npc+4 combinationally.
- br_taken  in  1  conditional branch taken.
- br_target  in  32  branch target.
- jmp_valid  in  1  JMPL/CALL redirect.
- jmp_target  in  32  jump target.
- trap_req  in  1  trap request; held by requester until trap_ack.
- trap_type  in  8  trap type, sampled with trap_req.
- et  in  1  traps enabled (PSR.ET).
- pc  out  32  current fetch address.
- npc  out  32  next PC; feeds PC4 adder.
- pc_valid  out  1  instruction at pc is not annulled/bubbled.
- trap_ack  out  1  one-cycle pulse, trap accepted.
- error_mode  out  1  processor halted in error mode.
- misalign  out  1  misaligned target detected (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, npc=RESET_PC+4, pc_valid=1.
  - trap_ack=0, error_mode=0, misalign=0, state=RUN.
- All updates occur on the rising clk edge. Outputs are registered except misalign, which is combinational.
- States:
  - RUN: normal sequencing.
  - TRAP_LOAD: one-cycle trap vector load.
  - ERROR: halted.
- RUN, trap_req=1, et=1 (trap overrides stall, jmp, branch and annul):
  - npc<=vector; pc held; pc_valid<=0; trap_ack<=1; goto TRAP_LOAD.
- RUN, trap_req=1, et=0:
  - goto ERROR; error_mode<=1; pc_valid<=0.
- RUN, stall=1: all registers hold; trap_ack<=0.
- RUN, normal advance:
  - pc<=npc.
  - npc<= jmp_valid ? jmp_target : br_taken ? br_target : npc_plus4. jmp_valid wins over br_taken if both are asserted.
  - pc_valid<=~annul.
- TRAP_LOAD:
  - trap_ack<=0.
  - If stall, hold. Otherwise pc<=npc (vector), npc<=npc_plus4 (vector+4), pc_valid<=1, goto RUN.
  - trap_req, jmp_valid, br_taken and annul are ignored in this state.
- ERROR:
  - pc, npc frozen; pc_valid=0; error_mode=1.
  - Exit only via reset.
- Arithmetic: no internal adder for sequencing; npc+4 comes only from npc_plus4. Vector concatenation is the only address formation. 32-bit wrap-around at 32'hFFFF_FFFC -> 0 comes naturally from the adder.
- Reset asserted mid-trap returns to RUN at RESET_PC with no trap_ack.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - misalign = RUN & ~stall & selected npc source has bits[1:0]!=0.
  - A misalign is handled exactly as trap_req with trap_type=8'h07, and takes priority over the misaligned redirect.
  - With et=0 it enters ERROR.
- Undefined:
  - misalign tied 0.
  - Targets are loaded unchecked; the low 2 bits pass through.

Test Plan:
- Reset release, 3 cycles no events -> pc 0,4,8,12; npc 4,8,12,16; pc_valid=1.
- At pc=8, npc=12, br_taken=1, br_target=0x100 -> next pc=12 (delay slot), npc=0x100; then pc=0x100, npc=0x104.
- Same branch with annul=1 -> pc=12 with pc_valid=0; next cycle pc=0x100 with pc_valid=1.
- trap_req=1, trap_type=0x05, et=1, TRAP_BASE=0x40000 -> one-cycle trap_ack, then npc=0x4000_0050.
  - Next cycle pc=0x4000_0050, npc=0x4000_0054.
  - stall asserted the same cycle does not block trap entry.
- trap_req=1 with et=0 -> error_mode=1, pc_valid=0, pc frozen for 10 cycles; rst_n pulse -> pc=0, error_mode=0.
- PC_ALIGN_CHECK_EN defined: jmp_target=0x202 -> misalign=1, trap_ack pulse, npc=vector of type 0x07. Undefined: npc=0x202.
